// File: rtl/seq_alu_if.sv
// Request/response bundle between the decode stage and seq_alu write-back.
interface seq_alu_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             ban;
  logic             err;

  modport master (output in_valid, op, in_a, in_b, out_ready,
                  input  in_ready, out_valid, out_data, ban, err);
  modport slave  (input  in_valid, op, in_a, in_b, out_ready,
                  output in_ready, out_valid, out_data, ban, err);
endinterface

// File: rtl/seq_alu.sv
// Registered ALU with Z/N/C flags and branch-test qualifier.
// Define SEQ_ALU_MUL_EN to build op 1100 as a WIDTH-cycle shift-add multiply.
module seq_alu #(parameter int WIDTH = 16) (
  input  logic     clk,
  input  logic     rst,
  seq_alu_if.slave bus,
  output logic     flag_z,
  output logic     flag_n,
  output logic     flag_c,
  output logic     busy
);
  localparam logic [3:0] OP_ZERO = 4'b0000, OP_NOT = 4'b0001, OP_ASR = 4'b0010,
                         OP_ROL  = 4'b0011, OP_ADD = 4'b0100, OP_PA  = 4'b0101,
                         OP_PB   = 4'b0110, OP_BR  = 4'b0111, OP_SUB = 4'b1000,
                         OP_AND  = 4'b1001, OP_OR  = 4'b1010, OP_XOR = 4'b1011,
                         OP_MUL  = 4'b1100;

  logic [WIDTH-1:0] a, b, res, mul_res, dreg;
  logic             vreg, breg, ereg;
  logic             accept, is_mul, ld_mul;
  logic             c_nxt, c_upd, zn_upd, ban_nxt, err_nxt;

  assign a             = bus.in_a;
  assign b             = bus.in_b;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = vreg;
  assign bus.out_data  = dreg;
  assign bus.ban       = breg;
  assign bus.err       = ereg;

  always_comb begin
    res     = '0;
    c_nxt   = 1'b0;
    c_upd   = 1'b0;
    zn_upd  = 1'b1;
    ban_nxt = 1'b0;
    err_nxt = 1'b0;
    case (bus.op)
      OP_ZERO: res = '0;
      OP_NOT:  res = ~a;
      OP_ASR:  begin res = {a[WIDTH-1], a[WIDTH-1:1]}; c_nxt = a[0]; c_upd = 1'b1; end
      OP_ROL:  begin res = {a[WIDTH-2:0], a[WIDTH-1]}; c_nxt = a[WIDTH-1]; c_upd = 1'b1; end
      OP_ADD:  begin {c_nxt, res} = {1'b0, a} + {1'b0, b}; c_upd = 1'b1; end
      OP_PA:   res = a;
      OP_PB:   res = b;
      OP_BR:   begin res = a; ban_nxt = a[WIDTH-1]; zn_upd = 1'b0; end
      OP_SUB:  begin res = a - b; c_nxt = (a < b); c_upd = 1'b1; end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
`ifdef SEQ_ALU_MUL_EN
      OP_MUL:  ;  // result arrives through the shift-add path
`endif
      default: begin zn_upd = 1'b0; err_nxt = 1'b1; end
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  typedef enum logic {IDLE, MUL} state_t;
  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand, mplier, acc;
  logic             last;

  assign is_mul       = (bus.op == OP_MUL);
  assign last         = (cnt == CW'(WIDTH-1));
  assign mul_res      = acc + (mplier[0] ? mcand : '0);
  assign bus.in_ready = (state == IDLE) && (!vreg || bus.out_ready);

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    ld_mul    = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: if (accept && is_mul) state_nxt = MUL;
      MUL: begin
        busy = 1'b1;
        if (last) begin
          ld_mul    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One partial product per cycle: multiplicand walks left, multiplier walks right.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (accept && is_mul) begin
      cnt    <= '0;
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (busy) begin
      cnt    <= cnt + CW'(1);
      mcand  <= {mcand[WIDTH-2:0], 1'b0};
      mplier <= mplier >> 1;
      acc    <= mul_res;
    end
`else
  assign is_mul       = 1'b0;
  assign ld_mul       = 1'b0;
  assign mul_res      = '0;
  assign busy         = 1'b0;
  assign bus.in_ready = !vreg || bus.out_ready;
`endif

  // Output register only loads when the previous result is gone or being taken.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vreg   <= 1'b0;
      dreg   <= '0;
      breg   <= 1'b0;
      ereg   <= 1'b0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
    end else if (accept && !is_mul) begin
      vreg <= 1'b1;
      dreg <= res;
      breg <= ban_nxt;
      ereg <= err_nxt;
      if (zn_upd) begin
        flag_z <= (res == '0);
        flag_n <= res[WIDTH-1];
      end
      if (c_upd) flag_c <= c_nxt;
    end else if (ld_mul) begin
      vreg   <= 1'b1;
      dreg   <= mul_res;
      breg   <= 1'b0;
      ereg   <= 1'b0;
      flag_z <= (mul_res == '0);
      flag_n <= mul_res[WIDTH-1];
    end else if (bus.out_ready) begin
      vreg <= 1'b0;
    end
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed vectors, expected results queued at accept.
module tb_seq_alu;
  localparam int W = 16;
  localparam logic [3:0] ZERO = 4'b0000, NOT = 4'b0001, ASR = 4'b0010, ROL = 4'b0011,
                         ADD  = 4'b0100, PA  = 4'b0101, PB  = 4'b0110, BR  = 4'b0111,
                         SUB  = 4'b1000, AND = 4'b1001, OR  = 4'b1010, XOR = 4'b1011,
                         MUL  = 4'b1100, R13 = 4'b1101, R15 = 4'b1111;

  typedef struct packed {
    logic [W-1:0] d;
    logic         ban, err, z, n, c;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flag_z, flag_n, flag_c, busy;
  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   nres = 0;

  seq_alu_if #(.WIDTH(W)) bus ();
  seq_alu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus), .flag_z(flag_z),
                            .flag_n(flag_n), .flag_c(flag_c), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t ex(input logic [W-1:0] d, input logic bn, er, z, n, c);
    return {d, bn, er, z, n, c};
  endfunction

  // Monitor: every consumed result must match the head of the queue.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      nres++;
      if (q.size() == 0) begin
        chk($sformatf("unexpected_result#%0d", nres), 32'(bus.out_data), 32'hDEAD_BEEF);
      end else begin
        e = q.pop_front();
        chk($sformatf("result#%0d {data,ban,err,z,n,c}", nres),
            32'({bus.out_data, bus.ban, bus.err, flag_z, flag_n, flag_c}), 32'(e));
      end
    end
  end

  // Issue one request; returns the number of negedges spent waiting for in_ready.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input exp_t e, input bit push, output int waits);
    waits = 0;
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.in_a     = a;
    bus.in_b     = b;
    do begin
      @(negedge clk);
      waits++;
    end while (!bus.in_ready && waits < 50);
    if (!bus.in_ready) begin
      chk("accept_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (push) q.push_back(e);
  endtask

  // Single-cycle op: result must be presented one edge after accept.
  task automatic op1(input string name, input logic [3:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input exp_t e);
    int w;
    send(op, a, b, e, 1'b1, w);
    chk({name, "_latency"}, 32'(bus.out_valid), 32'd1);
    chk({name, "_accept_wait"}, 32'(w), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  w, n, bcnt;
    bit  seen;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.op        = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;

    #12;
    chk("rst_outputs {valid,data,ban,err,z,n,c,busy}",
        32'({bus.out_valid, bus.out_data, bus.ban, bus.err, flag_z, flag_n, flag_c, busy}), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    op1("add_wrap", ADD, 16'hFFFF, 16'h0001, ex(16'h0000, 0, 0, 1, 0, 1));
    op1("asr",      ASR, 16'h8002, 16'h0000, ex(16'hC001, 0, 0, 0, 1, 0));
    op1("rol",      ROL, 16'h8001, 16'h0000, ex(16'h0003, 0, 0, 0, 0, 1));
    op1("br_neg",   BR,  16'h8000, 16'h1234, ex(16'h8000, 1, 0, 0, 0, 1));
    op1("br_pos",   BR,  16'h7FFF, 16'h0000, ex(16'h7FFF, 0, 0, 0, 0, 1));

    // Backpressure: result must hold and block the next request.
    repeat (2) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    op1("sub_borrow", SUB, 16'h0001, 16'h0002, ex(16'hFFFF, 0, 0, 0, 1, 1));
    bus.in_valid = 1'b1;
    bus.op       = AND;
    bus.in_a     = 16'h0F0F;
    bus.in_b     = 16'h00FF;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_hold {valid,data}", 32'({bus.out_valid, bus.out_data}), 32'h1FFFF);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    q.push_back(ex(16'h000F, 0, 0, 0, 0, 1));
    chk("no_bubble {valid,data}", 32'({bus.out_valid, bus.out_data}), 32'h1000F);

    // Back-to-back stream at full throughput.
    op1("zero", ZERO, 16'h1234, 16'h5678, ex(16'h0000, 0, 0, 1, 0, 1));
    op1("not",  NOT,  16'h00FF, 16'h0000, ex(16'hFF00, 0, 0, 0, 1, 1));
    op1("pa",   PA,   16'h1234, 16'hFFFF, ex(16'h1234, 0, 0, 0, 0, 1));
    op1("pb",   PB,   16'h1234, 16'h8000, ex(16'h8000, 0, 0, 0, 1, 1));
    op1("or",   OR,   16'h00F0, 16'h0F00, ex(16'h0FF0, 0, 0, 0, 0, 1));
    op1("xor",  XOR,  16'hFFFF, 16'hFFFF, ex(16'h0000, 0, 0, 1, 0, 1));
    op1("sub",  SUB,  16'h0005, 16'h0003, ex(16'h0002, 0, 0, 0, 0, 0));
    op1("add",  ADD,  16'h7FFF, 16'h0001, ex(16'h8000, 0, 0, 0, 1, 0));
    op1("rsv15", R15, 16'h1111, 16'h2222, ex(16'h0000, 0, 1, 0, 1, 0));
    op1("rsv13", R13, 16'h0000, 16'h0000, ex(16'h0000, 0, 1, 0, 1, 0));

`ifdef SEQ_ALU_MUL_EN
    send(MUL, 16'h0003, 16'h0005, ex(16'h000F, 0, 0, 0, 0, 0), 1'b1, w);
    n = 1;
    bcnt = 0;
    while (!bus.out_valid && n < 40) begin
      if (busy) bcnt++;
      chk("mul_in_ready_low", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      n++;
    end
    chk("mul_latency", 32'(n), 32'd17);
    chk("mul_busy_cycles", 32'(bcnt), 32'd16);
    chk("mul_busy_fall", 32'(busy), 32'd0);

    send(MUL, 16'h0100, 16'h0100, ex(16'h0000, 0, 0, 1, 0, 0), 1'b1, w);
    n = 1;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("mul_ovf_latency", 32'(n), 32'd17);

    // Abort a multiply in its 5th cycle.
    send(MUL, 16'h0003, 16'h0005, ex(16'h0000, 0, 0, 0, 0, 0), 1'b0, w);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_outputs {valid,data,ban,err,z,n,c,busy}",
        32'({bus.out_valid, bus.out_data, bus.ban, bus.err, flag_z, flag_n, flag_c, busy}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      if (bus.out_valid || busy) seen = 1'b1;
    end
    chk("abort_no_result", 32'(seen), 32'd0);
`else
    op1("mul_rsv", MUL, 16'h0003, 16'h0005, ex(16'h0000, 0, 1, 0, 1, 0));
    chk("mul_rsv_busy", 32'(busy), 32'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
